// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// One transaction at a time over req/gnt/rvalid; responses are registered back to the owner.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    input  logic                  if_kill_i,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [DATA_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    input  logic [3:0]            d_be_i,
    output logic                  d_done_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  stall_f_o,
    output logic                  stall_m_o
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             drop;
    logic             busy_we;
    logic             pick_d;
    logic             grant_d;
    logic             grant_f;
    logic             drop_now;

    always_comb begin
        pick_d      = d_req_i & (~if_req_i | (starve_cnt < CNT_MAX));
        state_nxt   = state;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        grant_d     = 1'b0;
        grant_f     = 1'b0;
        case (state)
            IDLE: begin
                mem_req_o = ~rst & (if_req_i | d_req_i);
                if (pick_d) begin
                    mem_we_o    = d_we_i;
                    mem_addr_o  = d_addr_i;
                    mem_wdata_o = d_wdata_i;
                    mem_be_o    = d_be_i;
                end else begin
                    mem_addr_o  = if_addr_i;
                    mem_be_o    = 4'hF;
                end
                grant_d = mem_req_o & mem_gnt_i & pick_d;
                grant_f = mem_req_o & mem_gnt_i & ~pick_d;
                if (grant_d) begin
                    state_nxt = BUSY_D;
                end else if (grant_f) begin
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_rvalid_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A kill arriving on the response cycle itself still discards that response.
    assign drop_now = drop | if_kill_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt  <= '0;
            drop        <= 1'b0;
            busy_we     <= 1'b0;
            if_rvalid_o <= 1'b0;
            d_done_o    <= 1'b0;
            if_rdata_o  <= '0;
            d_rdata_o   <= '0;
        end else begin
            if_rvalid_o <= 1'b0;
            d_done_o    <= 1'b0;

            if (!if_req_i || grant_f) begin
                starve_cnt <= '0;
            end else if (grant_d && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end

            if (grant_d) begin
                busy_we <= d_we_i;
            end
            if (grant_f && if_kill_i) begin
                drop <= 1'b1;
            end

            if (state == BUSY_IF) begin
                if (mem_rvalid_i) begin
                    drop <= 1'b0;
                    if (!drop_now) begin
                        if_rvalid_o <= 1'b1;
                        if_rdata_o  <= mem_rdata_i;
                    end
                end else if (if_kill_i) begin
                    drop <= 1'b1;
                end
            end

            if (state == BUSY_D && mem_rvalid_i) begin
                d_done_o <= 1'b1;
                if (!busy_we) begin
                    d_rdata_o <= mem_rdata_i;
                end
            end
        end
    end

    assign stall_f_o = if_req_i & ~if_rvalid_o;
    assign stall_m_o = d_req_i & ~d_done_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level
// memory/requester model with its own word store.
module tb_mem_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i, if_kill_i, if_rvalid_o;
    logic [DW-1:0] if_addr_i, if_rdata_o;
    logic          d_req_i, d_we_i, d_done_o;
    logic [DW-1:0] d_addr_i, d_wdata_i, d_rdata_o;
    logic [3:0]    d_be_i, mem_be_o;
    logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [DW-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic          stall_f_o, stall_m_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
        .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .stall_f_o(stall_f_o), .stall_m_o(stall_m_o)
    );

    int unsigned checks = 0;
    int unsigned failures = 0;

    // memory agent and transaction model state
    logic [31:0] mem_m [int unsigned];
    int unsigned gnt_pct = 100, lat_min = 1, lat_max = 1;
    bit          pend, pend_d, pend_we, pend_killed, pend_flushed;
    int unsigned pend_left;
    logic [31:0] pend_rdata;
    bit          m_busy;
    int unsigned fcount;
    bit          exp_if_v, exp_d_v;
    logic [31:0] m_if_rd, m_d_rd;
    bit          grant_log [$];
    bit          rand_mode;
    int unsigned f_prob, d_prob, kill_pct;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_m.exists(a >> 2)) return mem_m[a >> 2];
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic void wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] w;
        w = rd(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        mem_m[a >> 2] = w;
    endfunction

    task automatic step_begin();
        bit last_kill;
        @(posedge clk);
        #1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        if (pend && pend_left > 0) begin
            pend_left--;
            if (pend_left == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pend_rdata;
            end
        end
        mem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
        last_kill = if_kill_i;
        if_kill_i = 1'b0;
        if (rand_mode) begin
            if (if_req_i && (if_rvalid_o || last_kill)) if_req_i = 1'b0;
            if (!if_req_i && $urandom_range(0, 99) < f_prob) begin
                if_req_i  = 1'b1;
                if_addr_i = 32'($urandom_range(0, 63)) << 2;
            end
            if_kill_i = if_req_i && ($urandom_range(0, 99) < kill_pct);
            if (d_req_i && d_done_o) d_req_i = 1'b0;
            if (!d_req_i && $urandom_range(0, 99) < d_prob) begin
                d_req_i   = 1'b1;
                d_we_i    = 1'($urandom_range(0, 1));
                d_addr_i  = 32'($urandom_range(0, 63)) << 2;
                d_wdata_i = $urandom;
                d_be_i    = 4'($urandom_range(1, 15));
            end
        end else begin
            if (if_rvalid_o) if_req_i = 1'b0;
            if (d_done_o) d_req_i = 1'b0;
        end
    endtask

    task automatic step_end();
        bit exp_req, win_d, acc, n_if_v, n_d_v;
        logic [31:0] n_if_rd, n_d_rd;
        @(negedge clk);
        chk1("if_rvalid", if_rvalid_o, exp_if_v);
        chk32("if_rdata", if_rdata_o, m_if_rd);
        chk1("d_done", d_done_o, exp_d_v);
        chk32("d_rdata", d_rdata_o, m_d_rd);
        chk1("stall_f", stall_f_o, if_req_i & ~exp_if_v);
        chk1("stall_m", stall_m_o, d_req_i & ~exp_d_v);
        exp_req = !rst && !m_busy && (if_req_i || d_req_i);
        chk1("mem_req", mem_req_o, exp_req);
        win_d = d_req_i && (!if_req_i || fcount < SL);
        if (exp_req) begin
            if (win_d) begin
                chk1("mem_we", mem_we_o, d_we_i);
                chk32("mem_addr", mem_addr_o, d_addr_i);
                chk32("mem_wdata", mem_wdata_o, d_wdata_i);
                chk32("mem_be", 32'(mem_be_o), 32'(d_be_i));
            end else begin
                chk1("mem_we", mem_we_o, 1'b0);
                chk32("mem_addr", mem_addr_o, if_addr_i);
                chk32("mem_wdata", mem_wdata_o, 32'h0);
                chk32("mem_be", 32'(mem_be_o), 32'hF);
            end
        end
        if (mem_req_o === 1'b1 && mem_gnt_i) grant_log.push_back(d_req_i && (mem_addr_o === d_addr_i));

        n_if_v = 0; n_d_v = 0; n_if_rd = m_if_rd; n_d_rd = m_d_rd;
        acc = exp_req && mem_gnt_i && !pend;
        if (acc) begin
            pend = 1; pend_d = win_d; pend_flushed = 0;
            pend_we = win_d && d_we_i;
            pend_killed = !win_d && if_kill_i;
            pend_left = $urandom_range(lat_min, lat_max);
            if (!win_d) pend_rdata = rd(if_addr_i);
            else if (!d_we_i) pend_rdata = rd(d_addr_i);
            else begin
                wr(d_addr_i, d_wdata_i, d_be_i);
                pend_rdata = $urandom;
            end
            m_busy = 1;
        end else if (pend && !pend_d && !pend_flushed && if_kill_i) begin
            pend_killed = 1;
        end
        if (mem_rvalid_i && pend && !acc) begin
            if (!pend_flushed) begin
                m_busy = 0;
                if (!pend_d) begin
                    if (!pend_killed) begin n_if_v = 1; n_if_rd = mem_rdata_i; end
                end else begin
                    n_d_v = 1;
                    if (!pend_we) n_d_rd = mem_rdata_i;
                end
            end
            pend = 0;
        end
        if (!if_req_i) fcount = 0;
        else if (acc && !win_d) fcount = 0;
        else if (acc && win_d && fcount < SL) fcount++;
        if (rst) begin
            n_if_v = 0; n_d_v = 0; n_if_rd = '0; n_d_rd = '0;
            m_busy = 0; fcount = 0;
            if (pend) pend_flushed = 1;
        end
        exp_if_v = n_if_v; exp_d_v = n_d_v; m_if_rd = n_if_rd; m_d_rd = n_d_rd;
    endtask

    task automatic tick();
        step_begin();
        step_end();
    endtask

    task automatic drain(input int unsigned max);
        bit quiet;
        quiet = 0;
        for (int unsigned i = 0; i < max; i++) begin
            if (!if_req_i && !d_req_i && !pend && !m_busy) begin quiet = 1; break; end
            tick();
        end
        if (!quiet) quiet = !if_req_i && !d_req_i && !pend && !m_busy;
        chk1("drain", quiet, 1'b1);
    endtask

    initial begin
        bit          exp_order [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
        logic [31:0] f_pc, d_pc, saved;
        bit          seen;

        rst = 1; if_req_i = 0; if_addr_i = 0; if_kill_i = 0;
        d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0; d_be_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        mem_m[32'h100 >> 2] = 32'h0050_0093;
        mem_m[32'h104 >> 2] = 32'h1234_5678;
        mem_m[32'h200 >> 2] = 32'h0000_0013;

        // reset, with a fetch already requesting
        tick();
        step_begin(); if_req_i = 1; if_addr_i = 32'h100; step_end();
        chk1("rst_mem_req", mem_req_o, 1'b0);
        chk1("rst_if_rvalid", if_rvalid_o, 1'b0);
        chk1("rst_d_done", d_done_o, 1'b0);
        chk32("rst_if_rdata", if_rdata_o, 32'h0);
        chk32("rst_d_rdata", d_rdata_o, 32'h0);

        // 1: plain fetch
        step_begin(); rst = 0; step_end();
        chk1("t1_req", mem_req_o, 1'b1);
        chk32("t1_addr", mem_addr_o, 32'h100);
        chk32("t1_be", 32'(mem_be_o), 32'hF);
        chk1("t1_we", mem_we_o, 1'b0);
        tick();
        chk1("t1_stall_busy", stall_f_o, 1'b1);
        step_begin(); if_req_i = 1; if_addr_i = 32'h180; step_end();
        chk1("t1_rvalid", if_rvalid_o, 1'b1);
        chk32("t1_rdata", if_rdata_o, 32'h0050_0093);
        chk1("t1_stall_low", stall_f_o, 1'b0);
        tick();
        chk1("t1_rvalid_end", if_rvalid_o, 1'b0);
        chk1("t1_stall_back", stall_f_o, 1'b1);
        drain(20);

        // 2: both requesting continuously
        grant_log.delete();
        f_pc = 32'h400; d_pc = 32'h800;
        for (int i = 0; i < 60 && grant_log.size() < 11; i++) begin
            step_begin();
            if (!if_req_i) begin if_req_i = 1; if_addr_i = f_pc; f_pc += 4; end
            if (!d_req_i) begin
                d_req_i = 1; d_we_i = 0; d_addr_i = d_pc; d_pc += 4;
                d_be_i = 4'hF; d_wdata_i = 0;
            end
            step_end();
        end
        chk1("t2_grant_count", grant_log.size() >= 11, 1'b1);
        for (int i = 0; i < 11; i++)
            if (i < grant_log.size()) chk1($sformatf("t2_order%0d", i), grant_log[i], exp_order[i]);
        drain(30);

        // 3: store with partial byte enables
        saved = m_d_rd;
        step_begin();
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'b0011;
        step_end();
        chk1("t3_we", mem_we_o, 1'b1);
        chk32("t3_be", 32'(mem_be_o), 32'h3);
        chk32("t3_addr", mem_addr_o, 32'h2000);
        chk32("t3_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        tick();
        tick();
        chk1("t3_done", d_done_o, 1'b1);
        chk32("t3_rdata_kept", d_rdata_o, saved);
        drain(20);

        // 4: fetch killed while in flight, then redirected
        saved = m_if_rd;
        lat_min = 2; lat_max = 2;
        step_begin(); if_req_i = 1; if_addr_i = 32'h104; step_end();
        step_begin(); if_kill_i = 1; step_end();
        step_begin(); if_addr_i = 32'h200; step_end();
        step_begin(); step_end();
        chk1("t4_no_rvalid", if_rvalid_o, 1'b0);
        chk32("t4_rdata_kept", if_rdata_o, saved);
        chk1("t4_stall", stall_f_o, 1'b1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if_rvalid_o === 1'b1) begin
                seen = 1;
                chk32("t4_refetch", if_rdata_o, 32'h0000_0013);
                break;
            end
        end
        chk1("t4_refetch_seen", seen, 1'b1);
        lat_min = 1; lat_max = 1;
        drain(20);

        // 5: grant withheld, data arrives and wins
        gnt_pct = 0;
        step_begin(); if_req_i = 1; if_addr_i = 32'h300; step_end();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            chk1($sformatf("t5_req%0d", i), mem_req_o, 1'b1);
            chk32($sformatf("t5_addr%0d", i), mem_addr_o, 32'h300);
        end
        gnt_pct = 100;
        step_begin();
        mem_gnt_i = 1;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h500; d_be_i = 4'hF; d_wdata_i = 0;
        step_end();
        chk32("t5_data_wins", mem_addr_o, 32'h500);
        drain(30);

        // 6: reset during a data transaction, late response ignored
        lat_min = 3; lat_max = 3;
        step_begin(); d_req_i = 1; d_we_i = 0; d_addr_i = 32'h600; d_be_i = 4'hF; step_end();
        step_begin(); rst = 1; d_req_i = 0; gnt_pct = 0; mem_gnt_i = 0; step_end();
        chk1("t6_req_in_rst", mem_req_o, 1'b0);
        step_begin(); rst = 0; step_end();
        chk32("t6_if_rdata", if_rdata_o, 32'h0);
        chk32("t6_d_rdata", d_rdata_o, 32'h0);
        tick();
        tick();
        chk1("t6_late_done", d_done_o, 1'b0);
        chk32("t6_late_rdata", d_rdata_o, 32'h0);
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        step_begin(); if_req_i = 1; if_addr_i = 32'h100; step_end();
        chk1("t6_idle_req", mem_req_o, 1'b1);
        drain(20);

        // randomized traffic
        rand_mode = 1; gnt_pct = 60; lat_min = 1; lat_max = 3;
        f_prob = 70; d_prob = 50; kill_pct = 8;
        repeat (800) tick();
        rand_mode = 0; gnt_pct = 100;
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
